// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first.
// Define SERIAL_ADDER_OVERFLOW_EN to add the signed overflow output.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
`ifdef SERIAL_ADDER_OVERFLOW_EN
    output logic             overflow_o,
`endif
    output logic             carry_out_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] cnt;
    logic             carry;

    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;
    logic [WIDTH-1:0] work_next;

    // Single full-adder cell on the low bits and the running carry.
    always_comb begin
        fa_sum    = a_sr[0] ^ b_sr[0] ^ carry;
        fa_carry  = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
        last_bit  = (cnt == LAST);
        work_next = {fa_sum, work[WIDTH-1:1]};
    end

    // Control FSM plus serial datapath; results only move on RUN->DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            sum_o       <= '0;
            carry_out_o <= 1'b0;
            a_sr        <= '0;
            b_sr        <= '0;
            work        <= '0;
            cnt         <= '0;
            carry       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        a_sr   <= a_i;
                        b_sr   <= b_i;
                        carry  <= carry_in_i;
                        work   <= '0;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    work  <= work_next;
                    carry <= fa_carry;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        sum_o       <= work_next;
                        carry_out_o <= fa_carry;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (state == RUN && last_bit) begin
            overflow_o <= carry ^ fa_carry;
        end
    end
`else
    // Without the overflow option no signed-overflow state is kept.
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8).
// Immediate assertions at every comparison point.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic       ovf;
`endif

    int total  = 0;
    int passes = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .a_i        (a),
        .b_i        (b),
        .carry_in_i (cin),
        .busy_o     (busy),
        .done_o     (done),
        .sum_o      (sum),
`ifdef SERIAL_ADDER_OVERFLOW_EN
        .overflow_o (ovf),
`endif
        .carry_out_o(cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start_op(input logic [7:0] av, input logic [7:0] bv,
                            input logic cv);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    int n;
    int seen;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'h00);
        check("rst_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0;
        tick();

        // FF + 01 wraps to 0 with carry out
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done("t2a_to", n);
        check("t2a_sum", {24'd0, sum}, 32'h00);
        check("t2a_cout", {31'd0, cout}, 32'd1);
        tick();

        // FF + 00 + cin wraps the same way
        start_op(8'hFF, 8'h00, 1'b1);
        wait_done("t2b_to", n);
        check("t2b_sum", {24'd0, sum}, 32'h00);
        check("t2b_cout", {31'd0, cout}, 32'd1);
        tick();

        // 5A + 3C: busy 8 cycles, done on the 9th
        start_op(8'h5A, 8'h3C, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("t1_busy", {31'd0, busy}, 32'd1);
            check("t1_nodone", {31'd0, done}, 32'd0);
            check("t1_hold", {24'd0, sum}, 32'h00);
            tick();
        end
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_idle_busy", {31'd0, busy}, 32'd0);
        check("t1_sum", {24'd0, sum}, 32'h96);
        check("t1_cout", {31'd0, cout}, 32'd0);
        tick();
        check("t1_pulse", {31'd0, done}, 32'd0);

        // 10 + 20 with a start/operand change mid-run
        start_op(8'h10, 8'h20, 1'b0);
        tick();
        tick();
        a     = 8'hAA;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_busy", {31'd0, busy}, 32'd1);
        check("t3_hold", {24'd0, sum}, 32'h96);
        wait_done("t3_to", n);
        check("t3_lat", n, 32'd5);
        check("t3_sum", {24'd0, sum}, 32'h30);
        check("t3_cout", {31'd0, cout}, 32'd0);
        tick();

        // reset during RUN aborts the operation
        start_op(8'h12, 8'h34, 1'b0);
        tick();
        tick();
        tick();
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_done", {31'd0, done}, 32'd0);
        check("t4_sum", {24'd0, sum}, 32'h00);
        check("t4_cout", {31'd0, cout}, 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        check("t4_nopulse", seen, 32'd0);

        // reset and start together: reset wins
        a     = 8'h01;
        b     = 8'h01;
        start = 1'b1;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("t5_busy", {31'd0, busy}, 32'd0);
        tick();
        check("t5_still", {31'd0, busy}, 32'd0);

        start_op(8'h01, 8'h01, 1'b0);
        wait_done("t4b_to", n);
        check("t4b_lat", n, 32'd8);
        check("t4b_sum", {24'd0, sum}, 32'h02);
        check("t4b_cout", {31'd0, cout}, 32'd0);

        // back-to-back: restart on first IDLE cycle after done
        tick();
        start_op(8'hA5, 8'h5A, 1'b1);
        check("t6_busy", {31'd0, busy}, 32'd1);
        wait_done("t6_to", n);
        check("t6_gap", n + 2, 32'd10);
        check("t6_sum", {24'd0, sum}, 32'h00);
        check("t6_cout", {31'd0, cout}, 32'd1);
        tick();

`ifdef SERIAL_ADDER_OVERFLOW_EN
        start_op(8'h7F, 8'h01, 1'b0);
        wait_done("t7a_to", n);
        check("t7a_sum", {24'd0, sum}, 32'h80);
        check("t7a_cout", {31'd0, cout}, 32'd0);
        check("t7a_ovf", {31'd0, ovf}, 32'd1);
        tick();
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done("t7b_to", n);
        check("t7b_ovf", {31'd0, ovf}, 32'd0);
        check("t7b_cout", {31'd0, cout}, 32'd1);
        tick();
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
